// File: rtl/eth_sb_axi_slv_mem.sv
// eth_sb_axi_slv_mem: sideband bus slave over a word memory with RO top region and wait states; define ETH_SB_SLV_ERR_CNT_EN for o_err_cnt.
module eth_sb_axi_slv_mem #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int RO_WORDS = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_axi_mread,
  input  logic                    i_axi_mwrite,
  input  logic [ADDR_WIDTH-1:0]   i_axi_maddr,
  input  logic [DATA_WIDTH-1:0]   i_axi_mdata,
  input  logic [DATA_WIDTH/8-1:0] i_axi_mwstrb,
  input  logic                    i_axi_mready,
  output logic                    o_axi_saccept,
  output logic                    o_axi_svalid,
  output logic [2:0]              o_axi_sresp,
  output logic [DATA_WIDTH-1:0]   o_axi_sdata,
`ifdef ETH_SB_SLV_ERR_CNT_EN
  output logic [7:0]              o_err_cnt,
`endif
  output logic                    o_busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_A = ADDR_WIDTH'(MEM_DEPTH - RO_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NB-1:0] strb_q, strb_d;
  logic saccept_q, saccept_d, svalid_q, svalid_d;
  logic [2:0] sresp_q, sresp_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic borrow;
  logic [ADDR_WIDTH-1:0] off, idx;
  logic [IW-1:0] widx;
  logic [2:0] resp;
  logic done, we;
  // borrow out of the subtraction flags addresses below the window
  assign {borrow, off} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign idx = off >> 2;
  assign widx = idx[IW-1:0];
  assign resp = (borrow || idx >= DEPTH_A) ? 3'b110 :
                ((|addr_q[1:0]) || (rd_q && wr_q) || (wr_q && idx >= RO_A)) ? 3'b100 : 3'b000;
  assign done = state_q == S_WAIT && cnt_q == CW'(WAIT_CYCLES);
  assign we = done && wr_q && resp == 3'b000;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    strb_d = strb_q;
    saccept_d = 1'b0;
    svalid_d = svalid_q;
    sresp_d = sresp_q;
    sdata_d = sdata_q;
    case (state_q)
      S_IDLE: if (i_axi_mread || i_axi_mwrite) begin
        rd_d = i_axi_mread;
        wr_d = i_axi_mwrite;
        addr_d = i_axi_maddr;
        data_d = i_axi_mdata;
        strb_d = i_axi_mwstrb;
        cnt_d = '0;
        saccept_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (done) begin
        svalid_d = 1'b1;
        sresp_d = resp;
        sdata_d = (rd_q && resp == 3'b000) ? mem[widx] : '0;
        state_d = S_RESP;
      end else cnt_d = cnt_q + 1'b1;
      S_RESP: if (i_axi_mready) begin
        svalid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      saccept_q <= 1'b0;
      svalid_q <= 1'b0;
      sresp_q <= 3'b000;
      sdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      strb_q <= strb_d;
      saccept_q <= saccept_d;
      svalid_q <= svalid_d;
      sresp_q <= sresp_d;
      sdata_q <= sdata_d;
    end
  always_ff @(posedge i_clk)
    if (we)
      for (int b = 0; b < NB; b++)
        if (strb_q[b]) mem[widx][8*b +: 8] <= data_q[8*b +: 8];
`ifdef ETH_SB_SLV_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  assign err_cnt_d = (svalid_q && i_axi_mready && sresp_q != 3'b000 && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  assign o_err_cnt = err_cnt_q;
`endif
  assign o_axi_saccept = saccept_q;
  assign o_axi_svalid = svalid_q;
  assign o_axi_sresp = sresp_q;
  assign o_axi_sdata = sdata_q;
  assign o_busy = state_q != S_IDLE;
endmodule

// File: tb/tb_eth_sb_axi_slv_mem.sv
// tb_eth_sb_axi_slv_mem: randomized scoreboard bench for eth_sb_axi_slv_mem against a word-array reference model.
module tb_eth_sb_axi_slv_mem;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst, mread, mwrite, mready;
  logic [23:0] maddr;
  logic [31:0] mdata;
  logic [3:0] mwstrb;
  logic saccept, svalid, busy;
  logic [2:0] sresp;
  logic [31:0] sdata;
`ifdef ETH_SB_SLV_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  typedef struct {
    logic [2:0] resp;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;
  exp_t q[$];
  logic [31:0] mdl[256];
  logic [3:0] kn[256];
  int checks = 0, errors = 0, cyc = 0, t_req = 0, hs_cyc = 0, exp_err = 0;
  bit timed = 0, rdy_force = 0, rdy_val = 1;
  eth_sb_axi_slv_mem #(.WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_reset(rst), .i_axi_mread(mread), .i_axi_mwrite(mwrite),
    .i_axi_maddr(maddr), .i_axi_mdata(mdata), .i_axi_mwstrb(mwstrb), .i_axi_mready(mready),
    .o_axi_saccept(saccept), .o_axi_svalid(svalid), .o_axi_sresp(sresp), .o_axi_sdata(sdata),
`ifdef ETH_SB_SLV_ERR_CNT_EN
    .o_err_cnt(err_cnt),
`endif
    .o_busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask
  // reference: word array with per-byte "known" flags; unwritten bytes are don't-care
  function automatic exp_t model(bit rd, bit wr, logic [23:0] a, logic [31:0] d, logic [3:0] s, bit commit);
    exp_t e;
    int idx = int'(a) >> 2;
    e.data = 0;
    e.mask = '1;
    if (idx >= 256) e.resp = 3'b110;
    else if (a[1:0] != 2'b00 || (rd && wr) || (wr && idx >= 240)) e.resp = 3'b100;
    else begin
      e.resp = 3'b000;
      if (wr) begin
        if (commit)
          for (int b = 0; b < 4; b++)
            if (s[b]) begin
              mdl[idx][8*b +: 8] = d[8*b +: 8];
              kn[idx][b] = 1'b1;
            end
      end else begin
        e.data = mdl[idx];
        for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{kn[idx][b]}};
      end
    end
    return e;
  endfunction
  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  task automatic issue(bit rd, bit wr, logic [23:0] a, logic [31:0] d, logic [3:0] s,
                       bit blk, bit tmd, bit commit, output int acc);
    bit got = 0;
    q.push_back(model(rd, wr, a, d, s, commit));
    @(posedge clk); #1;
    mread = rd; mwrite = wr; maddr = a; mdata = d; mwstrb = s;
    t_req = cyc; timed = tmd; acc = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (saccept) begin got = 1; acc = cyc; end
    end
    chk("accepted", 32'(got), 1);
    if (got && tmd) chk("accept_latency", acc - t_req, 1);
    @(posedge clk); #1;
    mread = 0; mwrite = 0;
    if (blk) wait_drain();
  endtask
  initial begin
    mready = 1'b1;
    forever begin
      @(posedge clk); #2;
      mready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end
  initial begin
    bit sv_prev = 0, rdy_prev = 0;
    logic [2:0] hr = 0;
    logic [31:0] hd = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (svalid && !sv_prev && timed) chk("resp_latency", cyc - t_req, 2 + W);
      if (svalid && sv_prev && !rdy_prev) begin
        chk("hold_sresp", 32'(sresp), 32'(hr));
        chk("hold_sdata", sdata, hd);
      end
      if (svalid && mready) begin
        hs_cyc = cyc;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual resp=%0h data=%h expected none", sresp, sdata);
        end else begin
          e = q.pop_front();
          chk("sresp", 32'(sresp), 32'(e.resp));
          chk("sdata", sdata & e.mask, e.data & e.mask);
          if (e.resp != 3'b000 && exp_err < 255) exp_err++;
        end
      end
      sv_prev = svalid; rdy_prev = mready; hr = sresp; hd = sdata;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, sel;
    logic [23:0] a;
    bit rd, wr;
    rst = 1; mread = 0; mwrite = 0; maddr = 0; mdata = 0; mwstrb = 0;
    for (int i = 0; i < 256; i++) begin mdl[i] = 0; kn[i] = 0; end
    repeat (3) @(posedge clk); #1;
    chk("rst_saccept", 32'(saccept), 0);
    chk("rst_svalid", 32'(svalid), 0);
    chk("rst_sresp", 32'(sresp), 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef ETH_SB_SLV_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 0);
`endif
    rst = 0;
    issue(0, 1, 24'h10, 32'hCAFEBABE, 4'hF, 1, 1, 1, acc);
    issue(1, 0, 24'h10, 0, 0, 1, 1, 1, acc);
    issue(0, 1, 24'h10, 32'h11223344, 4'b0101, 1, 1, 1, acc);
    issue(1, 0, 24'h10, 0, 0, 1, 1, 1, acc);
    issue(0, 1, 24'h3C0, 32'hDEADBEEF, 4'hF, 1, 1, 1, acc);
    issue(1, 0, 24'h3C0, 0, 0, 1, 1, 1, acc);
    issue(1, 0, 24'h400, 0, 0, 1, 1, 1, acc);
    issue(1, 0, 24'h12, 0, 0, 1, 1, 1, acc);
    issue(1, 1, 24'h14, 32'h55AA55AA, 4'hF, 1, 1, 1, acc);
    issue(0, 1, 24'h10, 32'hFFFFFFFF, 4'h0, 1, 1, 1, acc);
    issue(1, 0, 24'h10, 0, 0, 1, 1, 1, acc);
    for (int i = 0; i < 240; i++) issue(0, 1, 24'(i * 4), $urandom, 4'hF, 1, 1, 1, acc);
    rdy_force = 1; rdy_val = 0;
    issue(1, 0, 24'h10, 0, 0, 0, 1, 1, acc);
    for (int i = 0; i < 20 && !svalid; i++) @(negedge clk);
    chk("stall_svalid", 32'(svalid), 1);
    repeat (5) @(negedge clk);
    rdy_val = 1;
    issue(1, 0, 24'h24, 0, 0, 0, 0, 1, acc);
    chk("b2b_accept", acc - hs_cyc, 2);
    wait_drain();
    rdy_force = 0;
    issue(0, 1, 24'h20, $urandom, 4'hF, 0, 1, 0, acc);
    rst = 1; #1;
    exp_err = 0;
    void'(q.pop_back());
    timed = 0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_svalid", 32'(svalid), 0);
    chk("mid_rst_saccept", 32'(saccept), 0);
    chk("mid_rst_sresp", 32'(sresp), 0);
    chk("mid_rst_sdata", sdata, 0);
`ifdef ETH_SB_SLV_ERR_CNT_EN
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    repeat (8) @(negedge clk);
    issue(1, 0, 24'h20, 0, 0, 1, 1, 1, acc);
    issue(1, 0, 24'h500, 0, 0, 1, 1, 1, acc);
    issue(0, 1, 24'h3FC, 32'h1, 4'hF, 1, 1, 1, acc);
    issue(1, 0, 24'h21, 0, 0, 1, 1, 1, acc);
`ifdef ETH_SB_SLV_ERR_CNT_EN
    @(posedge clk); #1;
    chk("err_cnt3", 32'(err_cnt), 3);
`endif
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      rd = $urandom_range(0, 1) != 0;
      wr = !rd;
      a = 24'($urandom_range(0, 255) * 4);
      if (sel == 6) a = a | 24'($urandom_range(1, 3));
      else if (sel == 7) a = 24'h400 + 24'($urandom_range(0, 4095));
      else if (sel == 8) a = 24'($urandom) | 24'h800000;
      else if (sel == 9) begin rd = 1; wr = 1; end
      issue(rd, wr, a, $urandom, 4'($urandom_range(0, 15)), 1, 1, 1, acc);
    end
    wait_drain();
`ifdef ETH_SB_SLV_ERR_CNT_EN
    @(posedge clk); #1;
    chk("err_cnt_final", 32'(err_cnt), 32'(exp_err));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_sb_axi_slv_mem.md
Name: eth_sb_axi_slv_mem

Overview:
- Downstream target of the sideband AXI-style master FSM: consumes its single-outstanding read/write command bus (mread/mwrite/maddr/mdata/mwstrb/mready) and returns saccept/svalid/sresp/sdata.
- Backs the bus with a local word-addressed register memory that has a read-only top region and programmable wait states.
- Used as the on-chip sideband scratch/config store and as the bus model for master-FSM regression.

Parameters:
- ADDR_WIDTH, 24, byte address width.
- DATA_WIDTH, 32, data width; byte strobes = DATA_WIDTH/8 (fixed 4 here).
- MEM_DEPTH, 256, number of words.
- BASE_ADDR, 24'h00_0000, byte address of word 0.
- RO_WORDS, 16, top RO_WORDS words are read-only (writes error).
- WAIT_CYCLES, 2, extra cycles between accept and response (0 legal).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; one clock, reset is asynchronous and active-high
- i_axi_mread  in  1  read request, held by master until o_axi_saccept
- i_axi_mwrite  in  1  write request, held by master until o_axi_saccept
- i_axi_maddr  in  ADDR_WIDTH  byte address
- i_axi_mdata  in  DATA_WIDTH  write data
- i_axi_mwstrb  in  4  byte write strobes
- i_axi_mready  in  1  master ready to take response
- o_axi_saccept  out  1  one-cycle command accept pulse
- o_axi_svalid  out  1  response valid, held until mready
- o_axi_sresp  out  3  3'b000 OKAY, 3'b100 SLVERR, 3'b110 DECERR
- o_axi_sdata  out  DATA_WIDTH  read data; 0 on write or error
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: saccept=0, svalid=0, sresp=3'b000, sdata=0, busy=0, state IDLE, wait counter 0. Memory array is not reset.
- States:
  - IDLE: if (mread|mwrite) in cycle N, latch op/addr/data/strb and go to WAIT; saccept=1 in cycle N+1 only.
  - WAIT: count WAIT_CYCLES cycles, then commit (write) or read memory, register sresp/sdata, go to RESP.
  - RESP: svalid=1; sresp/sdata stable while mready=0; on svalid&mready go to IDLE next cycle.
- Latency: svalid rises in cycle N+2+WAIT_CYCLES.
- Back-to-back: a request present in the first IDLE cycle after the handshake is captured; no bubble beyond that.
- mread/mwrite are ignored outside IDLE. A request still held while saccept is high is not re-accepted.
- Decode (on latched addr):
  - off = maddr - BASE_ADDR; idx = off>>2.
  - maddr < BASE_ADDR or idx >= MEM_DEPTH -> DECERR, no access, sdata=0.
  - maddr[1:0] != 0 -> SLVERR, no access.
  - write with idx >= MEM_DEPTH-RO_WORDS -> SLVERR, memory unchanged; reads of the RO region are OKAY.
  - mread & mwrite both high at capture -> SLVERR, no access.
- Write: update only the bytes whose wstrb bit is set. wstrb=0 -> OKAY, no change.
- Read: sdata = mem[idx]. Read of a word written in the previous transaction returns the new value.
- Reset mid-operation: return to IDLE immediately; an uncommitted write (still in WAIT) is dropped; outputs return to reset values.

Optional Feature:
- Macro ETH_SB_SLV_ERR_CNT_EN.
- Defined: adds port o_err_cnt out 8, counting responses with sresp != OKAY. Increments on the svalid&mready handshake, saturates at 8'hFF, cleared by i_reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Write 24'h00_0010 = 32'hCAFEBABE, wstrb 4'hF, then read 24'h00_0010 -> saccept pulse one cycle after request; svalid 4 cycles after request (WAIT_CYCLES=2); read returns sresp 3'b000, sdata 32'hCAFEBABE.
- Write 32'h11223344 with wstrb 4'b0101 over 32'hCAFEBABE at the same address, then read -> sdata 32'hCA22BA44.
- Write to 24'h00_03C0 (word 240, RO) -> sresp 3'b100, later read unchanged. Read 24'h00_0400 -> sresp 3'b110, sdata 0. Read 24'h00_0012 -> 3'b100.
- Hold mready=0 for 5 cycles during RESP -> svalid, sresp and sdata stable throughout; one handshake; next request accepted the cycle after return to IDLE.
- Assert i_reset during WAIT of a write to 24'h00_0020 -> outputs cleared, no svalid; a later read of 24'h00_0020 returns the pre-write value. With ETH_SB_SLV_ERR_CNT_EN, three errored responses -> o_err_cnt = 3.
